// File: rtl/ultra_meas_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ultra_meas_ctrl_pkg
// Shared definitions for the ultrasonic range-measurement controller:
// FSM state encoding, result width, centimetre divisor and a saturating
// increment helper.
// -----------------------------------------------------------------------------
package ultra_meas_ctrl_pkg;

    localparam int RESULT_W = 16;

    // Round-trip echo time per centimetre of range.
    localparam logic [RESULT_W-1:0] US_PER_CM  = 16'd58;
    localparam logic [RESULT_W-1:0] RESULT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_CALC      = 3'd4,
        ST_HOLDOFF   = 3'd5
    } measState_t;

    function automatic logic [RESULT_W-1:0] satInc(input logic [RESULT_W-1:0] v);
        return (v == RESULT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ultra_meas_ctrl_us_tick_gen.sv
// -----------------------------------------------------------------------------
// us_tick_gen
// Produces a single-cycle pulse every TICK_DIV clock cycles while iRun is high.
// iClear zeroes the phase in the cycle it is asserted, so the first tick after
// a clear arrives exactly TICK_DIV cycles later (counting the clear cycle).
//
// Ports
//   iClk    in   system clock
//   iRst    in   asynchronous reset, active-high
//   iRun    in   count enable; count held at zero while low
//   iClear  in   restart the tick phase this cycle
//   oTick   out  one-cycle tick pulse (combinational from count)
// -----------------------------------------------------------------------------
module us_tick_gen
    import ultra_meas_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iRun,
    input  logic iClear,
    output logic oTick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cntEff;

    // The clear cycle itself counts as phase 0.
    assign cntEff = iClear ? '0 : cnt;
    assign oTick  = iRun && (cntEff == CW'(TICK_DIV - 1));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt <= '0;
        end else if (!iRun) begin
            cnt <= '0;
        end else if (oTick) begin
            cnt <= '0;
        end else begin
            cnt <= cntEff + 1'b1;
        end
    end

endmodule

// File: rtl/ultra_meas_ctrl.sv
// -----------------------------------------------------------------------------
// ultra_meas_ctrl
// Ultrasonic range sensor controller: issues a trigger pulse, times the echo
// pulse in microseconds, optionally converts to centimetres, then enforces a
// quiet hold-off before the next measurement.
//
// Optional feature macro: ULTRA_DIST_CALC_EN
//   defined   : CALC converts us to cm by repeated subtraction of 58, one
//               step per cycle (at most 1130 cycles).
//   undefined : CALC lasts one cycle and oDist is the raw us count.
//
// Ports
//   iClk    in   system clock
//   iRst    in   asynchronous reset, active-high
//   iStart  in   measurement request, honoured only in IDLE
//   iEcho   in   sensor echo, asynchronous to iClk
//   oTrig   out  sensor trigger pulse
//   oBusy   out  high whenever not IDLE
//   oValid  out  one-cycle pulse, oDist updated in the same cycle
//   oError  out  one-cycle pulse on timeout, oDist unchanged
//   oDist   out  last result
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for iStart
// TRIG       | driving oTrig for TRIG_US microseconds
// WAIT_RISE  | waiting for echo rise, timeout after TIMEOUT_US
// MEASURE    | counting echo width in us, timeout at TIMEOUT_US
// CALC       | producing oDist, pulses oValid
// HOLDOFF    | quiet time of HOLDOFF_US before returning to IDLE
// -----------------------------------------------------------------------------
module ultra_meas_ctrl
    import ultra_meas_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 100,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int HOLDOFF_US = 60000
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic                iEcho,
    output logic                oTrig,
    output logic                oBusy,
    output logic                oValid,
    output logic                oError,
    output logic [RESULT_W-1:0] oDist
);

    measState_t state;
    measState_t statePrev;

    logic echoMeta;
    logic echoSync;
    logic echoDly;
    logic echoRise;
    logic echoFall;

    logic tick;
    logic tickRun;
    logic tickClr;

    logic [31:0]         phaseCnt;
    logic [RESULT_W-1:0] usCnt;
    logic [RESULT_W-1:0] usNext;

`ifdef ULTRA_DIST_CALC_EN
    logic [RESULT_W-1:0] calcRem;
    logic [RESULT_W-1:0] calcQuo;
`endif

    // Echo synchroniser plus one delay stage for edge detection.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            echoMeta <= 1'b0;
            echoSync <= 1'b0;
            echoDly  <= 1'b0;
        end else begin
            echoMeta <= iEcho;
            echoSync <= echoMeta;
            echoDly  <= echoSync;
        end
    end

    assign echoRise = echoSync & ~echoDly;
    assign echoFall = ~echoSync & echoDly;

    // First cycle in any new state restarts the microsecond phase.
    assign tickRun = (state != ST_IDLE);
    assign tickClr = (state != statePrev);

    us_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) uTickGen (
        .iClk   (iClk),
        .iRst   (iRst),
        .iRun   (tickRun),
        .iClear (tickClr),
        .oTick  (tick)
    );

    // A tick coinciding with the fall edge still counts, so an echo of N us
    // measures exactly N.
    assign usNext = tick ? satInc(usCnt) : usCnt;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= ST_IDLE;
            statePrev <= ST_IDLE;
            oTrig     <= 1'b0;
            oBusy     <= 1'b0;
            oValid    <= 1'b0;
            oError    <= 1'b0;
            oDist     <= '0;
            phaseCnt  <= '0;
            usCnt     <= '0;
`ifdef ULTRA_DIST_CALC_EN
            calcRem   <= '0;
            calcQuo   <= '0;
`endif
        end else begin
            statePrev <= state;
            oValid    <= 1'b0;
            oError    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        state    <= ST_TRIG;
                        oTrig    <= 1'b1;
                        oBusy    <= 1'b1;
                        phaseCnt <= 32'(TRIG_US - 1);
                    end
                end

                ST_TRIG: begin
                    if (tick) begin
                        if (phaseCnt == 32'd0) begin
                            state    <= ST_WAIT_RISE;
                            oTrig    <= 1'b0;
                            phaseCnt <= 32'(TIMEOUT_US - 1);
                        end else begin
                            phaseCnt <= phaseCnt - 32'd1;
                        end
                    end
                end

                ST_WAIT_RISE: begin
                    // Fall edges here belong to a stale echo and are ignored.
                    if (echoRise) begin
                        state <= ST_MEASURE;
                        usCnt <= '0;
                    end else if (tick) begin
                        if (phaseCnt == 32'd0) begin
                            state    <= ST_HOLDOFF;
                            oError   <= 1'b1;
                            phaseCnt <= 32'(HOLDOFF_US - 1);
                        end else begin
                            phaseCnt <= phaseCnt - 32'd1;
                        end
                    end
                end

                ST_MEASURE: begin
                    usCnt <= usNext;
                    if (echoFall) begin
                        state <= ST_CALC;
`ifdef ULTRA_DIST_CALC_EN
                        calcRem <= usNext;
                        calcQuo <= '0;
`endif
                    end else if (tick && ({16'd0, usNext} >= 32'(TIMEOUT_US))) begin
                        state    <= ST_HOLDOFF;
                        oError   <= 1'b1;
                        phaseCnt <= 32'(HOLDOFF_US - 1);
                    end
                end

                ST_CALC: begin
`ifdef ULTRA_DIST_CALC_EN
                    if (calcRem >= US_PER_CM) begin
                        calcRem <= calcRem - US_PER_CM;
                        calcQuo <= calcQuo + 1'b1;
                    end else begin
                        state    <= ST_HOLDOFF;
                        oDist    <= calcQuo;
                        oValid   <= 1'b1;
                        phaseCnt <= 32'(HOLDOFF_US - 1);
                    end
`else
                    state    <= ST_HOLDOFF;
                    oDist    <= usCnt;
                    oValid   <= 1'b1;
                    phaseCnt <= 32'(HOLDOFF_US - 1);
`endif
                end

                ST_HOLDOFF: begin
                    if (tick) begin
                        if (phaseCnt == 32'd0) begin
                            state <= ST_IDLE;
                            oBusy <= 1'b0;
                        end else begin
                            phaseCnt <= phaseCnt - 32'd1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    oTrig <= 1'b0;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultra_meas_ctrl.sv
module tb_ultra_meas_ctrl;

    localparam int TD   = 4;
    localparam int TRIG = 10;
    localparam int TMO  = 700;
    localparam int HOLD = 200;

`ifdef ULTRA_DIST_CALC_EN
    localparam int EXP_580 = 10;
    localparam int EXP_116 = 2;
    localparam int EXP_57  = 0;
    localparam int EXP_1   = 0;
`else
    localparam int EXP_580 = 580;
    localparam int EXP_116 = 116;
    localparam int EXP_57  = 57;
    localparam int EXP_1   = 1;
`endif

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iStart = 1'b0;
    logic        iEcho = 1'b0;
    logic        oTrig;
    logic        oBusy;
    logic        oValid;
    logic        oError;
    logic [15:0] oDist;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int trigRises = 0, trigFalls = 0, trigHigh = 0;
    int validCnt = 0, errCnt = 0, busyFalls = 0;
    int trigFallCyc = 0, errCyc = 0, busyFallCyc = 0;
    int validDist = 0, errDist = 0;
    logic prevTrig = 1'b0, prevBusy = 1'b0;

    int bTrigHigh, bRise, bValid, bErr, echoCyc;

    ultra_meas_ctrl #(
        .TICK_DIV   (TD),
        .TRIG_US    (TRIG),
        .TIMEOUT_US (TMO),
        .HOLDOFF_US (HOLD)
    ) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iStart (iStart),
        .iEcho  (iEcho),
        .oTrig  (oTrig),
        .oBusy  (oBusy),
        .oValid (oValid),
        .oError (oError),
        .oDist  (oDist)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc++;

    always @(negedge iClk) begin
        if (oTrig) trigHigh++;
        if (oTrig && !prevTrig) trigRises++;
        if (!oTrig && prevTrig) begin
            trigFalls++;
            trigFallCyc = cyc;
        end
        if (oValid) begin
            validCnt++;
            validDist = int'(oDist);
        end
        if (oError) begin
            errCnt++;
            errCyc = cyc;
            errDist = int'(oDist);
        end
        if (!oBusy && prevBusy) begin
            busyFalls++;
            busyFallCyc = cyc;
        end
        prevTrig = oTrig;
        prevBusy = oBusy;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int evCount(input int sel);
        case (sel)
            0:       return trigFalls;
            1:       return validCnt;
            2:       return errCnt;
            default: return busyFalls;
        endcase
    endfunction

    // sel: 0 trigger fall, 1 valid, 2 error, 3 busy fall
    task automatic waitEvent(input int sel, input int budget, input string tag);
        int base = evCount(sel);
        int n = 0;
        while (evCount(sel) == base && n < budget) begin
            @(negedge iClk);
            n++;
        end
        check(tag, int'(evCount(sel) != base), 1);
    endtask

    task automatic startPulse();
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
    endtask

    task automatic measure(input int us, input int expDist, input string tag);
        startPulse();
        waitEvent(0, 100, "trig_fall_wait");
        repeat (2) @(negedge iClk);
        iEcho = 1'b1;
        repeat (us * TD) @(negedge iClk);
        iEcho = 1'b0;
        waitEvent(1, 2000, "valid_wait");
        check(tag, validDist, expDist);
        waitEvent(3, HOLD * TD + 50, "busy_fall_wait");
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge iClk);
        check("rst_trig",  int'(oTrig),  0);
        check("rst_busy",  int'(oBusy),  0);
        check("rst_valid", int'(oValid), 0);
        check("rst_error", int'(oError), 0);
        check("rst_dist",  int'(oDist),  0);
        iRst = 1'b0;
        @(negedge iClk);

        // 580 us echo
        bTrigHigh = trigHigh;
        bValid = validCnt;
        bErr = errCnt;
        startPulse();
        waitEvent(0, 100, "trig_fall_wait");
        check("trig_width", trigHigh - bTrigHigh, TRIG * TD);
        check("busy_in_wait", int'(oBusy), 1);
        repeat (5) @(negedge iClk);
        iEcho = 1'b1;
        repeat (580 * TD) @(negedge iClk);
        iEcho = 1'b0;
        waitEvent(1, 2000, "valid_wait_580");
        check("dist_580", validDist, EXP_580);
        check("dist_port_580", int'(oDist), EXP_580);
        waitEvent(3, HOLD * TD + 50, "busy_fall_580");
        check("valid_cnt_580", validCnt - bValid, 1);
        check("err_cnt_580", errCnt - bErr, 0);
        check("dist_held", int'(oDist), EXP_580);

        // No echo: timeout in WAIT_RISE
        bValid = validCnt;
        startPulse();
        waitEvent(0, 100, "trig_fall_wait");
        waitEvent(2, TMO * TD + 50, "err_wait_noecho");
        check("noecho_err_latency", errCyc - trigFallCyc, TMO * TD);
        check("noecho_dist_unchanged", errDist, EXP_580);
        waitEvent(3, HOLD * TD + 50, "busy_fall_noecho");
        check("noecho_holdoff", busyFallCyc - errCyc, HOLD * TD);
        check("noecho_no_valid", validCnt - bValid, 0);

        // Echo stuck high, iStart repeated during MEASURE and HOLDOFF
        bRise = trigRises;
        bValid = validCnt;
        bErr = errCnt;
        startPulse();
        waitEvent(0, 100, "trig_fall_wait");
        repeat (3) @(negedge iClk);
        iEcho = 1'b1;
        echoCyc = cyc;
        repeat (200) @(negedge iClk);
        startPulse();
        repeat (100) @(negedge iClk);
        startPulse();
        waitEvent(2, TMO * TD + 50, "err_wait_stuck");
        check("stuck_err_cycle", errCyc - echoCyc, TMO * TD + 3);
        iEcho = 1'b0;
        repeat (100) @(negedge iClk);
        startPulse();
        waitEvent(3, HOLD * TD + 50, "busy_fall_stuck");
        repeat (10) @(negedge iClk);
        check("stuck_no_extra_trig", trigRises - bRise, 1);
        check("stuck_no_valid", validCnt - bValid, 0);
        check("stuck_one_err", errCnt - bErr, 1);

        // Echo already high in IDLE: new trigger, but no measurement starts
        bValid = validCnt;
        bErr = errCnt;
        iEcho = 1'b1;
        repeat (5) @(negedge iClk);
        startPulse();
        waitEvent(0, 100, "trig_fall_wait");
        check("new_trig_in_idle", trigRises - bRise, 2);
        waitEvent(2, TMO * TD + 50, "err_wait_highidle");
        check("highidle_no_valid", validCnt - bValid, 0);
        check("highidle_err", errCnt - bErr, 1);
        iEcho = 1'b0;
        waitEvent(3, HOLD * TD + 50, "busy_fall_highidle");

        // Reset mid-MEASURE
        bValid = validCnt;
        bErr = errCnt;
        startPulse();
        waitEvent(0, 100, "trig_fall_wait");
        repeat (2) @(negedge iClk);
        iEcho = 1'b1;
        repeat (100) @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        check("midrst_trig",  int'(oTrig),  0);
        check("midrst_busy",  int'(oBusy),  0);
        check("midrst_valid", int'(oValid), 0);
        check("midrst_error", int'(oError), 0);
        check("midrst_dist",  int'(oDist),  0);
        iEcho = 1'b0;
        @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);
        measure(116, EXP_116, "dist_116");
        check("midrst_valid_cnt", validCnt - bValid, 1);
        check("midrst_err_cnt", errCnt - bErr, 0);

        // Short echoes
        measure(57, EXP_57, "dist_57");
        measure(1, EXP_1, "dist_1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
